mat_mult_stream: RTL and testbench

//  Upstream/downstream wrapper for the 6x6 48-bit matrix multiplier in the IK datapath.

---
 rtl/mat_mult_pkg.sv | 20 ++
 rtl/mat_mult_stream_rc.sv | 34 +++
 rtl/mat_mult_stream.sv | 128 ++++++++++++
 tb/tb_mat_mult_stream.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// Shared types for the streaming 6x6 matrix-multiply wrapper.
// Matrix geometry, element type and controller states.
package mat_mult_pkg;
   localparam int N      = 6;
   localparam int WORD_W = 48;
   localparam int NN     = N * N;
   localparam int IDX_W  = $clog2(NN);
   localparam int RC_W   = $clog2(N);

   typedef logic [WORD_W-1:0] word_t;
   typedef word_t [N-1:0][N-1:0] mat_t;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      CLEAR,
      COMPUTE,
      DRAIN
   } state_t;
endpackage

// File: rtl/mat_mult_stream_rc.sv
// Row/column element counter for row-major matrix streams.
// Wraps to 0,0 after the last element; no divide needed.
module mat_rc_counter
   import mat_mult_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            inc,
   output logic [RC_W-1:0] row,
   output logic [RC_W-1:0] col,
   output logic            last
);

   localparam logic [RC_W-1:0] MAX = RC_W'(N - 1);

   assign last = (row == MAX) && (col == MAX);

   // step column, carry into row, wrap after the final element
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col == MAX) begin
            col <= '0;
            row <= last ? '0 : row + RC_W'(1);
         end else begin
            col <= col + RC_W'(1);
         end
      end
   end

endmodule

// File: rtl/mat_mult_stream.sv
// Word-stream wrapper around the wide-port matrix multiplier.
// Loads A then B, runs the multiplier, drains the product.
module mat_mult_stream
   import mat_mult_pkg::*;
#(
   parameter int MM_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              mm_en,
   output logic              mm_rst,
   output logic              mm_mat_mode,
   output mat_t              mm_dataa,
   output mat_t              mm_datab,
   input  mat_t              mm_result
);

   localparam int LAT_W = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MM_LATENCY - 1);

   state_t           state;
   state_t           state_nxt;
   logic [LAT_W-1:0] lat_q;
   logic [RC_W-1:0]  row;
   logic [RC_W-1:0]  col;
   logic             last;
   logic             in_fire;
   logic             out_fire;
   logic             lat_done;
   mat_t             a_q;
   mat_t             b_q;
   mat_t             res_q;
   logic             mode_q;

   assign in_fire     = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign lat_done    = (lat_q == LAT_MAX);
   assign out_data    = res_q[row][col];
   assign out_last    = out_valid && last;
   assign mm_dataa    = a_q;
   assign mm_datab    = b_q;
   assign mm_mat_mode = mode_q;

   mat_rc_counter u_rc (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == CLEAR),
      .inc  (in_fire || out_fire),
      .row  (row),
      .col  (col),
      .last (last)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD_A;
      else     state <= state_nxt;
   end

   // next state and handshake/multiplier controls
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mm_en     = 1'b0;
      mm_rst    = 1'b0;
      unique case (state)
         LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid && last) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid && last) state_nxt = CLEAR;
         end
         CLEAR: begin
            mm_rst    = 1'b1;
            state_nxt = COMPUTE;
         end
         COMPUTE: begin
            mm_en = 1'b1;
            if (lat_done) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && last) state_nxt = LOAD_A;
         end
         default: state_nxt = LOAD_A;
      endcase
      if (rst) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
         mm_en     = 1'b0;
         mm_rst    = 1'b1;
      end
   end

   // multiplier latency counter, bounded at MM_LATENCY-1
   always_ff @(posedge clk) begin
      if (rst || state != COMPUTE) lat_q <= '0;
      else if (lat_done)           lat_q <= '0;
      else                         lat_q <= lat_q + LAT_W'(1);
   end

   // mode is taken from the first A word only
   always_ff @(posedge clk) begin
      if (rst)
         mode_q <= 1'b0;
      else if (in_fire && state == LOAD_A && row == '0 && col == '0)
         mode_q <= in_mode;
   end

   // operand and result storage, never cleared
   always_ff @(posedge clk) begin
      if (in_fire && state == LOAD_A) a_q[row][col] <= in_data;
      if (in_fire && state == LOAD_B) b_q[row][col] <= in_data;
      if (state == COMPUTE && lat_done) res_q <= mm_result;
   end

endmodule

// File: tb/tb_mat_mult_stream.sv
// Randomized scoreboard bench for mat_mult_stream.
// Includes a Q24 multiplier model with fixed latency.
module tb_mat_mult_stream;
   import mat_mult_pkg::*;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   word_t       in_data;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   word_t       out_data;
   logic        out_last;
   logic        mm_en;
   logic        mm_rst;
   logic        mm_mat_mode;
   mat_t        mm_dataa;
   mat_t        mm_datab;
   mat_t        mm_result;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   word_t exp_q[$];
   bit    last_q[$];
   mat_t  exp_a;
   mat_t  exp_b;
   bit    exp_mode;
   int    last_b_cyc;
   bit    bp_on = 0;
   bit    rnd_bp = 0;
   int    bp_cnt = 0;

   mat_mult_stream #(.MM_LATENCY(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_mode     (in_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .mm_en       (mm_en),
      .mm_rst      (mm_rst),
      .mm_mat_mode (mm_mat_mode),
      .mm_dataa    (mm_dataa),
      .mm_datab    (mm_datab),
      .mm_result   (mm_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Q24 fixed-point product, plain arithmetic
   function automatic mat_t mm_ref(input mat_t a, input mat_t b);
      mat_t r;
      logic [127:0] acc;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int k = 0; k < N; k++)
               acc += 128'(a[i][k]) * 128'(b[k][j]);
            r[i][j] = word_t'(acc >> 24);
         end
      return r;
   endfunction

   function automatic word_t rnd48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   // multiplier model: product valid from the L-th enabled cycle
   int en_cnt = 0;
   always @(posedge clk) begin
      if (mm_rst)     en_cnt <= 0;
      else if (mm_en) en_cnt <= en_cnt + 1;
   end
   always_comb begin
      mm_result = mat_t'({NN{48'hDEAD_BEEF_0BAD}});
      if (en_cnt >= L - 1) mm_result = mm_ref(mm_dataa, mm_datab);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // output monitor: drives out_ready, pops scoreboard on transfer
   int    drain_idx = 0;
   bit    hold_v = 0;
   word_t hold_d;
   logic  hold_l;
   bit    prev_ov = 0;
   always @(negedge clk) begin
      if (hold_v) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_data", 64'(out_data), 64'(hold_d));
         chk("hold_last", 64'(out_last), 64'(hold_l));
      end
      if (out_valid) chk("in_ready_drain", 64'(in_ready), 64'd0);
      if (out_valid && !prev_ov)
         chk("latency", 64'(cyc - last_b_cyc), 64'(2 + L));
      if (bp_on && out_valid && drain_idx == 17 && bp_cnt < 3) begin
         out_ready = 1'b0;
         bp_cnt++;
      end else if (rnd_bp) begin
         out_ready = 1'($urandom_range(0, 1));
      end else begin
         out_ready = 1'b1;
      end
      hold_v = 0;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            word_t ew;
            bit    el;
            ew = exp_q.pop_front();
            el = last_q.pop_front();
            chk("out_data", 64'(out_data), 64'(ew));
            chk("out_last", 64'(out_last), 64'(el));
            if (el) begin
               chk("xfer_count", 64'(drain_idx + 1), 64'(NN));
               drain_idx = 0;
            end else begin
               drain_idx++;
            end
         end
      end else if (out_valid) begin
         hold_v = 1;
         hold_d = out_data;
         hold_l = out_last;
      end
      prev_ov = out_valid;
   end

   // multiplier-side monitor
   bit prev_en = 0;
   bit prev_rst = 0;
   int run = 0;
   always @(negedge clk) begin
      if (mm_en) begin
         if (!prev_en) chk("rst_before_en", 64'(prev_rst), 64'd1);
         chk("dataa", 64'(mm_dataa == exp_a), 64'd1);
         chk("datab", 64'(mm_datab == exp_b), 64'd1);
         chk("mat_mode", 64'(mm_mat_mode), 64'(exp_mode));
         chk("rst_low_en", 64'(mm_rst), 64'd0);
         run++;
      end else if (prev_en) begin
         chk("en_run", 64'(run), 64'(L));
         run = 0;
      end
      prev_en = mm_en;
      prev_rst = mm_rst;
   end

   task automatic reset_checks();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_mm_en", 64'(mm_en), 64'd0);
      chk("rst_mm_rst", 64'(mm_rst), 64'd1);
      chk("rst_mm_mode", 64'(mm_mat_mode), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      reset_checks();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_mm_rst", 64'(mm_rst), 64'd0);
   endtask

   // stream A then B; abort_at>=0 resets before that B word
   task automatic send_job(input mat_t a, input mat_t b, input bit mode1,
                           input bit gaps, input int abort_at);
      bit v = 0;
      for (int w = 0; w < 2 * NN; w++) begin
         word_t wd;
         bit acc = 0;
         int tmo = 0;
         if (abort_at >= 0 && w == NN + abort_at) begin
            do_reset();
            return;
         end
         wd = (w < NN) ? a[w / N][w % N] : b[(w - NN) / N][(w - NN) % N];
         while (!acc) begin
            bit rdy;
            @(negedge clk);
            v = gaps ? ~v : 1'b1;
            in_valid = v;
            in_data = v ? wd : rnd48();
            in_mode = (w == 0 && v) ? mode1 : ~mode1;
            rdy = in_ready;
            @(posedge clk);
            if (v && rdy) acc = 1;
            tmo++;
            if (tmo > 1000) begin
               chk("in_ready_timeout", 64'd0, 64'd1);
               return;
            end
         end
      end
      exp_a = a;
      exp_b = b;
      exp_mode = mode1;
      last_b_cyc = cyc;
      begin
         mat_t r;
         r = mm_ref(a, b);
         for (int k = 0; k < NN; k++) begin
            exp_q.push_back(r[k / N][k % N]);
            last_q.push_back(k == NN - 1);
         end
      end
   endtask

   function automatic mat_t rnd_mat();
      mat_t m;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m[i][j] = rnd48();
      return m;
   endfunction

   initial begin
      mat_t ia;
      mat_t rb;
      int tmo;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_mode = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_checks();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ia[i][j] = (i == j) ? word_t'(48'd1 << 24) : '0;
            rb[i][j] = word_t'(i * N + j);
         end
      send_job(ia, rb, 1'b0, 1'b0, -1);
      send_job(rnd_mat(), rnd_mat(), 1'b0, 1'b1, -1);
      bp_on = 1;
      send_job(rnd_mat(), rnd_mat(), 1'b0, 1'b0, -1);
      send_job(rnd_mat(), rnd_mat(), 1'b1, 1'b0, -1);

      tmo = 0;
      while (exp_q.size() != 0 && tmo < 2000) begin
         @(negedge clk);
         tmo++;
      end
      send_job(rnd_mat(), rnd_mat(), 1'b1, 1'b0, 10);
      send_job(rnd_mat(), rnd_mat(), 1'b0, 1'b1, -1);

      rnd_bp = 1;
      send_job(rnd_mat(), rnd_mat(), 1'b1, 1'b0, -1);
      send_job(rnd_mat(), rnd_mat(), 1'b0, 1'b0, -1);
      @(negedge clk);
      in_valid = 1'b0;

      tmo = 0;
      while ((exp_q.size() != 0 || out_valid) && tmo < 3000) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 3000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (5) @(negedge clk);
      chk("final_in_ready", 64'(in_ready), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
